// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multicycle control unit.
//   - RISC-V opcode constants recognised in DECODE
//   - ALUOp encodings driven on alu_op
//   - State encoding (visible on state_o) and the state enum
//   - ctrl_t: the per-state control word, plus decode_state(), which maps a
//     state and latched opcode to that word
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_WB_ALU = 4'd3;
  localparam logic [3:0] ST_ADDR   = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_WB_MEM = 4'd6;
  localparam logic [3:0] ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_BR     = 4'd8;
  localparam logic [3:0] ST_JMP    = 4'd9;
  localparam logic [3:0] ST_ERROR  = 4'd10;

  typedef enum logic [3:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_WB_ALU = ST_WB_ALU,
    S_ADDR   = ST_ADDR,
    S_MEM_RD = ST_MEM_RD,
    S_WB_MEM = ST_WB_MEM,
    S_MEM_WR = ST_MEM_WR,
    S_BR     = ST_BR,
    S_JMP    = ST_JMP,
    S_ERROR  = ST_ERROR
  } state_t;

  // Moore part of the outputs. 'fetch' and 'br' are not outputs themselves:
  // they qualify the two outputs that also depend on a live input
  // (ir_write/pc_write on mem_ready in FETCH, branch/pc_write on branch_flag in BR).
  typedef struct packed {
    logic       mem_read;
    logic       i_or_d;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_2_reg;
    logic       reg_write;
    logic       jump;
    logic       pc_write;
    logic       illegal;
    logic       fetch;
    logic       br;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.fetch    = 1'b1;
      end
      S_EXEC: begin
        c.alu_op  = ALUOP_RTYPE;
        c.alu_src = (op == OP_I);
      end
      S_WB_ALU: begin
        c.alu_op    = ALUOP_RTYPE;
        c.alu_src   = (op == OP_I);
        c.reg_write = 1'b1;
      end
      S_ADDR: begin
        c.alu_op  = ALUOP_ADD;
        c.alu_src = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.mem_2_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BR: begin
        c.alu_op = ALUOP_SUB;
        c.br     = 1'b1;
      end
      S_JMP: begin
        c.jump     = 1'b1;
        c.pc_write = 1'b1;
      end
      S_ERROR: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: datapath <-> control unit signal bundle.
//   master : the control unit (drives strobes, reads opcode/flags/mem_ready)
//   slave  : the datapath/memory side
// Handshake: a memory access is requested by holding mem_read or mem_write
// (with i_or_d selecting the address) high; it completes in the first cycle
// the slave returns mem_ready=1 while the request is high. mem_ready seen
// with no request pending is ignored.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       branch_flag;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_2_reg;
  logic       reg_write;
  logic       branch;
  logic       jump;
  logic       illegal;

  modport master (
    input  opcode, branch_flag, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, alu_src,
           alu_op, mem_2_reg, reg_write, branch, jump, illegal
  );

  modport slave (
    output opcode, branch_flag, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, alu_src,
           alu_op, mem_2_reg, reg_write, branch, jump, illegal
  );
endinterface

// File: rtl/mc_perf_counter.sv
// mc_perf_counter: free-running cycle counter and retired-instruction counter.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears both counters)
//   retire_i       one-cycle pulse per instruction retired
//   cycle_cnt_o    +1 every non-reset cycle, wraps
//   instret_cnt_o  +1 per retire_i pulse, wraps
module mc_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire_i) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle RISC-V datapath
// (R/I-type ALU, load, store, branch, jal). Unknown opcodes and memory
// timeouts park the FSM in a sticky ERROR state until rst.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ctrl_if         multicycle_control_if.master: opcode/branch_flag/mem_ready in,
//                   datapath strobes, alu_op and illegal out
//   state_o         current state encoding (debug)
//   cycle_cnt,      performance counters, present only when the macro
//   instret_cnt     MULTICYCLE_PERF_CNT_EN is defined
// Parameters: TIMEOUT_CYCLES (1..255) memory wait limit, CNT_W counter width.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  multicycle_control_if.master       ctrl_if,
  output logic [3:0]                 state_o
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           instret_cnt
`endif
);

  // Timeout fires in the cycle the wait counter would reach TIMEOUT_CYCLES.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       timeout;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    // mem_ready in the limit cycle wins over the timeout.
    timeout = !ctrl_if.mem_ready && (wait_q == WAIT_LAST);
    case (state_q)
      S_FETCH: begin
        if (ctrl_if.mem_ready) state_d = S_DECODE;
        else if (timeout)      state_d = S_ERROR;
      end
      S_DECODE: begin
        op_d = ctrl_if.opcode;
        case (ctrl_if.opcode)
          OP_R, OP_I:        state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BR;
          OP_JAL:            state_d = S_JMP;
          default:           state_d = S_ERROR;
        endcase
      end
      S_EXEC:   state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_ADDR:   state_d = (op_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (ctrl_if.mem_ready) state_d = S_WB_MEM;
        else if (timeout)      state_d = S_ERROR;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (ctrl_if.mem_ready) state_d = S_FETCH;
        else if (timeout)      state_d = S_ERROR;
      end
      S_BR:     state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // Counts only while waiting in a memory state; any state change clears it,
    // so each entry into FETCH/MEM_RD/MEM_WR starts from zero.
    if ((state_d == state_q) && (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}))
      wait_d = wait_q + 8'd1;
    else
      wait_d = 8'd0;

    ctrl_d = decode_state(state_d, op_d);
  end

  // Outputs are registered: ctrl_q always equals decode_state(state_q, op_q).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      ctrl_q  <= decode_state(S_FETCH, 7'd0);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // rst gates every output combinationally so nothing leaks while it is held,
  // including the partially completed instruction it abandons.
  assign state_o           = rst ? S_FETCH : state_q;
  assign ctrl_if.mem_read  = !rst && ctrl_q.mem_read;
  assign ctrl_if.i_or_d    = !rst && ctrl_q.i_or_d;
  assign ctrl_if.mem_write = !rst && ctrl_q.mem_write;
  assign ctrl_if.alu_src   = !rst && ctrl_q.alu_src;
  assign ctrl_if.alu_op    = rst ? ALUOP_ADD : ctrl_q.alu_op;
  assign ctrl_if.mem_2_reg = !rst && ctrl_q.mem_2_reg;
  assign ctrl_if.reg_write = !rst && ctrl_q.reg_write;
  assign ctrl_if.jump      = !rst && ctrl_q.jump;
  assign ctrl_if.illegal   = !rst && ctrl_q.illegal;
  assign ctrl_if.ir_write  = !rst && ctrl_q.fetch && ctrl_if.mem_ready;
  assign ctrl_if.branch    = !rst && ctrl_q.br && ctrl_if.branch_flag;
  assign ctrl_if.pc_write  = !rst && (ctrl_q.pc_write ||
                                      (ctrl_q.fetch && ctrl_if.mem_ready) ||
                                      (ctrl_q.br && ctrl_if.branch_flag));

`ifdef MULTICYCLE_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_raw, instret_raw;

  // FETCH is only re-entered from a completing state (WB_ALU, WB_MEM,
  // MEM_WR, BR, JMP); staying in FETCH is not a retire.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  mc_perf_counter #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst           (rst),
    .retire_i      (retire),
    .cycle_cnt_o   (cycle_raw),
    .instret_cnt_o (instret_raw)
  );

  assign cycle_cnt   = rst ? '0 : cycle_raw;
  assign instret_cnt = rst ? '0 : instret_raw;
`endif

endmodule
